// File: rtl/bk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bk_pkg
// Purpose  : Shared widths and FSM state encoding for the accumulation stage.
// Revision : 1.0 - initial release
// ============================================================================
package bk_pkg;

  localparam int BK_WIDTH = 20;
  localparam int BK_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } bk_state_e;

endpackage
`default_nettype wire

// File: rtl/PPA_Brent_Kung_20bit.sv
`default_nettype none
// ============================================================================
// Module   : PPA_Brent_Kung_20bit
// Purpose  : 20-bit parallel-prefix adder, Brent-Kung up-sweep/down-sweep tree.
// Revision : 1.0 - initial release
// ============================================================================
module PPA_Brent_Kung_20bit (
  input  logic [19:0] A,
  input  logic [19:0] B,
  input  logic        cin,
  output logic [19:0] S,
  output logic        cout
);

  localparam int N   = 20;
  localparam int LVL = 5;

  logic [N-1:0] w_gen;
  logic [N-1:0] w_prop;
  logic [N-1:0] w_gpfx;
  logic [N-1:0] w_ppfx;

  assign w_gen  = A & B;
  assign w_prop = A ^ B;

  // After the tree, w_gpfx[i] is the carry out of bit i (cin folded into bit 0).
  always_comb begin
    w_gpfx    = w_gen;
    w_ppfx    = w_prop;
    w_gpfx[0] = w_gen[0] | (w_prop[0] & cin);

    for (int l = 0; l < LVL; l++) begin
      for (int i = (1 << l); i < N; i++) begin
        if (((i + 1) % (1 << (l + 1))) == 0) begin
          w_gpfx[i] = w_gpfx[i] | (w_ppfx[i] & w_gpfx[i - (1 << l)]);
          w_ppfx[i] = w_ppfx[i] & w_ppfx[i - (1 << l)];
        end
      end
    end

    for (int l = LVL - 2; l >= 0; l--) begin
      for (int i = (1 << (l + 1)); i < N; i++) begin
        if (((i + 1) % (1 << (l + 1))) == (1 << l)) begin
          w_gpfx[i] = w_gpfx[i] | (w_ppfx[i] & w_gpfx[i - (1 << l)]);
          w_ppfx[i] = w_ppfx[i] & w_ppfx[i - (1 << l)];
        end
      end
    end
  end

  assign S    = w_prop ^ {w_gpfx[N-2:0], cin};
  assign cout = w_gpfx[N-1];

endmodule
`default_nettype wire

// File: rtl/bk_accumulate_stage.sv
`default_nettype none
// ============================================================================
// Module   : bk_accumulate_stage
// Purpose  : Streams len operands through a Brent-Kung adder into an
//            accumulator, counting carry-outs for an exact extended result.
// Revision : 1.0 - initial release
// ============================================================================
module bk_accumulate_stage
  import bk_pkg::*;
#(
  parameter int WIDTH = BK_WIDTH,
  parameter int CNT_W = BK_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_len,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_sum,
  output logic [CNT_W-1:0] o_out_carry,
  output logic             o_busy
);

  bk_state_e        r_state;
  bk_state_e        w_state_next;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_carry_cnt;
  logic [CNT_W-1:0] r_remaining;
  logic [WIDTH-1:0] w_add_sum;
  logic             w_add_cout;
  logic             w_beat;
  logic             w_job_start;

  assign w_beat      = (r_state == ST_ACCUM) && i_in_valid;
  assign w_job_start = (r_state == ST_IDLE) && i_start;

  PPA_Brent_Kung_20bit u_adder (
    .A    (r_acc),
    .B    (i_in_data),
    .cin  (1'b0),
    .S    (w_add_sum),
    .cout (w_add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_next = (i_len == '0) ? ST_DONE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (w_beat && (r_remaining == CNT_W'(1))) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (i_out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Carry count cannot wrap: a job of len beats produces at most len-1 carries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_carry_cnt <= '0;
      r_remaining <= '0;
    end else if (w_job_start) begin
      r_acc       <= '0;
      r_carry_cnt <= '0;
      r_remaining <= i_len;
    end else if (w_beat) begin
      r_acc       <= w_add_sum;
      r_carry_cnt <= r_carry_cnt + CNT_W'(w_add_cout);
      r_remaining <= r_remaining - CNT_W'(1);
    end
  end

  assign o_in_ready  = (r_state == ST_ACCUM);
  assign o_out_valid = (r_state == ST_DONE);
  assign o_busy      = (r_state != ST_IDLE);
  assign o_out_sum   = r_acc;
  assign o_out_carry = r_carry_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bk_accumulate_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_bk_accumulate_stage
// Purpose  : Randomized scoreboard bench for bk_accumulate_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bk_accumulate_stage;
  import bk_pkg::*;

  localparam int W  = BK_WIDTH;
  localparam int CW = BK_CNT_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [CW-1:0] i_len = '0;
  logic          i_in_valid = 1'b0;
  logic          o_in_ready;
  logic [W-1:0]  i_in_data = '0;
  logic          o_out_valid;
  logic          i_out_ready = 1'b0;
  logic [W-1:0]  o_out_sum;
  logic [CW-1:0] o_out_carry;
  logic          o_busy;

  typedef struct packed {
    logic [W-1:0]  sum;
    logic [CW-1:0] carry;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   rdy_mode = 0;  // 0 random, 1 hold low, 2 hold high

  always #5 clk = ~clk;

  bk_accumulate_stage #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_len       (i_len),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_data   (i_in_data),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_sum   (o_out_sum),
    .o_out_carry (o_out_carry),
    .o_busy      (o_busy)
  );

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Reference: the exact total of all operands, split at bit W.
  function automatic exp_t model(input int unsigned ops[$]);
    exp_t            r;
    longint unsigned total = 0;
    foreach (ops[k]) total += longint'(ops[k]);
    r.sum   = W'(total % (64'd1 << W));
    r.carry = CW'(total >> W);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (o_busy && n < 2000) begin
      tick();
      n++;
    end
    if (o_busy) check("idle_timeout", 1, 0);
  endtask

  task automatic start_job(input int len, input bit push, input int unsigned ops[$]);
    wait_idle();
    i_start   = 1'b1;
    i_len     = CW'(len);
    i_in_data = W'($urandom);
    if (push) exp_q.push_back(model(ops));
    tick();
    i_start = 1'b0;
    i_len   = CW'($urandom);
  endtask

  task automatic feed(input int unsigned ops[$], input int gap_pct, input int stop_after);
    int k = 0;
    int n = 0;
    while (k < ops.size() && k < stop_after && n < 5000) begin
      i_in_valid = ($urandom_range(0, 99) >= gap_pct);
      i_in_data  = i_in_valid ? W'(ops[k]) : W'($urandom);
      if (i_in_valid && o_in_ready) k++;
      tick();
      n++;
    end
    i_in_valid = 1'b0;
    if (n >= 5000) check("feed_timeout", 1, 0);
  endtask

  task automatic run_job(input int unsigned ops[$], input int gap_pct);
    start_job(ops.size(), 1'b1, ops);
    feed(ops, gap_pct, ops.size());
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       i_out_ready = ($urandom_range(0, 3) != 0);
        1:       i_out_ready = 1'b0;
        default: i_out_ready = 1'b1;
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (o_out_valid && i_out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_sum", o_out_sum, mon_e.sum);
          check("out_carry", o_out_carry, mon_e.carry);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned ops[$];
    exp_t        e;
    int          seen;
    int          n;

    #1;
    check("rst_in_ready", o_in_ready, 0);
    check("rst_out_valid", o_out_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_out_sum", o_out_sum, 0);
    check("rst_out_carry", o_out_carry, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // T1: abort mid-job, partial sum must vanish
    ops = {32'd1, 32'd2, 32'd3, 32'd4};
    start_job(4, 1'b0, ops);
    feed(ops, 0, 2);
    check("t1_busy_mid", o_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t1_abort_in_ready", o_in_ready, 0);
    check("t1_abort_out_valid", o_out_valid, 0);
    check("t1_abort_busy", o_busy, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    ops = {32'd7};
    run_job(ops, 0);

    // T2: latency of out_valid after the last beat
    ops = {32'd5, 32'd10, 32'd20};
    run_job(ops, 0);
    check("t2_valid_latency", o_out_valid, 1);
    check("t2_in_ready_done", o_in_ready, 0);

    // T3: single wrap
    ops = {32'hFFFFF, 32'h00001};
    run_job(ops, 0);

    // T4: 255*(2^20-1) = 254*2^20 + 0xFFF01
    ops.delete();
    repeat (255) ops.push_back(32'hFFFFF);
    run_job(ops, 30);

    // T5: zero-length job
    wait_idle();
    i_start = 1'b1;
    i_len   = '0;
    e.sum   = '0;
    e.carry = '0;
    exp_q.push_back(e);
    check("t5_in_ready_idle", o_in_ready, 0);
    tick();
    i_start = 1'b0;
    check("t5_done_next", o_out_valid, 1);
    check("t5_in_ready", o_in_ready, 0);
    check("t5_sum", o_out_sum, 0);
    check("t5_carry", o_out_carry, 0);
    seen = 0;
    n = 0;
    while (o_busy && n < 50) begin
      if (o_in_ready) seen = 1;
      tick();
      n++;
    end
    check("t5_in_ready_never", seen, 0);

    // T6: back-pressure in DONE
    rdy_mode = 1;
    ops = {32'h12345, 32'hABCDE};
    e = model(ops);
    run_job(ops, 0);
    for (int c = 0; c < 10; c++) begin
      check("t6_out_valid", o_out_valid, 1);
      check("t6_in_ready", o_in_ready, 0);
      check("t6_sum_stable", o_out_sum, e.sum);
      check("t6_carry_stable", o_out_carry, e.carry);
      i_start    = 1'($urandom_range(0, 1));
      i_len      = CW'($urandom_range(1, 255));
      i_in_valid = 1'b1;
      i_in_data  = W'($urandom);
      tick();
    end
    i_in_valid = 1'b0;
    i_start    = 1'b1;
    rdy_mode   = 2;
    tick();
    check("t6_released_valid", o_out_valid, 0);
    check("t6_released_busy", o_busy, 0);
    i_start = 1'b0;
    tick();
    check("t6_start_ignored", o_busy, 0);
    rdy_mode = 0;

    // Randomized jobs
    for (int j = 0; j < 10; j++) begin
      ops.delete();
      n = (j == 9) ? $urandom_range(100, 255) : $urandom_range(1, 20);
      for (int b = 0; b < n; b++) ops.push_back($urandom_range(0, (1 << W) - 1));
      run_job(ops, $urandom_range(0, 50));
    end

    wait_idle();
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      tick();
      n++;
    end
    check("scoreboard_drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
